// File: rtl/vx_wb_commit_arb.sv
// ---------------------------------------------------------------------------
// vx_wb_commit_arb
// Writeback commit arbiter. Merges NUM_INPUTS valid/ready commit ports onto
// the single valid-only writeback bus of the SIMT core. Multi-beat packets
// (sop..eop) are kept atomic by locking the arbiter to the owning port; the
// output is registered and all flow control is applied on the input side.
//
// Ports:
//   clk           clock
//   reset_n       synchronous active-low reset
//   valid_in      per-port beat valid
//   data_in       per-port payload, port i at [i*DATAW +: DATAW]
//   ready_in      per-port accept (combinational, one-hot or zero)
//   valid_out     registered writeback valid
//   data_out      registered writeback payload (holds when valid_out=0)
//   locked        a multi-beat packet is in progress
//   conflict_cnt  saturating count of cycles with a valid but ungranted port
// ---------------------------------------------------------------------------

// Simulation-only protocol and sanity checks for the commit arbiter.
module vx_wb_commit_arb_chk #(
  parameter int NUM_INPUTS = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  input logic                  lock_vld,
  input logic                  accept,
  input logic                  sop,
  input logic [NUM_INPUTS-1:0] valid_in,
  input logic [NUM_INPUTS-1:0] ready_in
);

  a_ready_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(ready_in));

  a_ready_needs_valid: assert property (@(posedge clk) disable iff (!reset_n)
    ((ready_in & ~valid_in) == {NUM_INPUTS{1'b0}}));

  // A new packet must not start on the port that already owns the lock.
  a_sop_while_locked: assert property (@(posedge clk) disable iff (!reset_n)
    !(lock_vld && accept && sop));

endmodule

module vx_wb_commit_arb #(
  parameter int NUM_INPUTS = 4,
  parameter int DATAW      = 128,
  parameter int CU_W       = 2,
  parameter int PERF_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_INPUTS-1:0]       valid_in,
  input  logic [NUM_INPUTS*DATAW-1:0] data_in,
  output logic [NUM_INPUTS-1:0]       ready_in,
  output logic                        valid_out,
  output logic [DATAW-1:0]            data_out,
  output logic                        locked,
  output logic [PERF_W-1:0]           conflict_cnt
);

  localparam int PTR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [PTR_W-1:0] LAST_ID = PTR_W'(NUM_INPUTS - 1);

  // Round-robin successor of a port id, wrapping at the last port.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] id);
    logic [PTR_W-1:0] nxt;
    if (id == LAST_ID) begin
      nxt = {PTR_W{1'b0}};
    end else begin
      nxt = id + PTR_W'(1);
    end
    return nxt;
  endfunction

  logic [PTR_W-1:0]      rr_ptr_r;
  logic                  lock_vld_r;
  logic [PTR_W-1:0]      lock_id_r;
  logic                  valid_out_r;
  logic [DATAW-1:0]      data_out_r;
  logic [PERF_W-1:0]     conflict_cnt_r;

  logic                  rr_hit_s;
  logic [PTR_W-1:0]      rr_id_s;
  logic                  gnt_vld_s;
  logic [PTR_W-1:0]      gnt_id_s;
  logic [NUM_INPUTS-1:0] ready_s;
  logic [DATAW-1:0]      beat_s;
  logic                  beat_sop_s;
  logic                  beat_eop_s;
  logic                  conflict_s;

  // Round-robin search starting at rr_ptr_r. The first pass finds the lowest
  // valid port below the pointer (wrap-around tail); the second pass finds the
  // lowest valid port at or above it and, when present, overrides the first.
  always_comb begin
    rr_hit_s = 1'b0;
    rr_id_s  = {PTR_W{1'b0}};
    for (int j = NUM_INPUTS - 1; j >= 0; j--) begin
      rr_hit_s = rr_hit_s | (valid_in[j] && (PTR_W'(j) < rr_ptr_r));
      rr_id_s  = (valid_in[j] && (PTR_W'(j) < rr_ptr_r)) ? PTR_W'(j) : rr_id_s;
    end
    for (int j = NUM_INPUTS - 1; j >= 0; j--) begin
      rr_hit_s = rr_hit_s | (valid_in[j] && (PTR_W'(j) >= rr_ptr_r));
      rr_id_s  = (valid_in[j] && (PTR_W'(j) >= rr_ptr_r)) ? PTR_W'(j) : rr_id_s;
    end
  end

  // Final grant: nothing during reset, only the lock owner while locked
  // (a bubble if it is idle), otherwise the round-robin winner.
  always_comb begin
    if (!reset_n) begin
      gnt_vld_s = 1'b0;
      gnt_id_s  = {PTR_W{1'b0}};
    end else if (lock_vld_r) begin
      gnt_vld_s = valid_in[lock_id_r];
      gnt_id_s  = lock_id_r;
    end else begin
      gnt_vld_s = rr_hit_s;
      gnt_id_s  = rr_id_s;
    end
  end

  // Decode the grant into ready_in and mux the accepted beat.
  always_comb begin
    ready_s = {NUM_INPUTS{1'b0}};
    beat_s  = {DATAW{1'b0}};
    for (int j = 0; j < NUM_INPUTS; j++) begin
      ready_s[j] = gnt_vld_s && (gnt_id_s == PTR_W'(j));
      beat_s     = beat_s | ({DATAW{ready_s[j]}} & data_in[j*DATAW +: DATAW]);
    end
  end

  assign beat_sop_s = beat_s[CU_W+1];
  assign beat_eop_s = beat_s[CU_W];
  assign conflict_s = |(valid_in & ~ready_s);

  // Arbiter state, lock tracking, output register and conflict counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_r       <= {PTR_W{1'b0}};
      lock_vld_r     <= 1'b0;
      lock_id_r      <= {PTR_W{1'b0}};
      valid_out_r    <= 1'b0;
      data_out_r     <= {DATAW{1'b0}};
      conflict_cnt_r <= {PERF_W{1'b0}};
    end else begin
      valid_out_r <= gnt_vld_s;
      if (gnt_vld_s) begin
        data_out_r <= beat_s;
      end else begin
        data_out_r <= data_out_r;
      end

      // eop always releases (this also covers single-beat packets); a sop
      // without eop opens the lock; middle beats leave the state alone.
      if (gnt_vld_s && beat_eop_s) begin
        lock_vld_r <= 1'b0;
        lock_id_r  <= lock_id_r;
        rr_ptr_r   <= next_ptr(gnt_id_s);
      end else if (gnt_vld_s && beat_sop_s) begin
        lock_vld_r <= 1'b1;
        lock_id_r  <= gnt_id_s;
        rr_ptr_r   <= rr_ptr_r;
      end else begin
        lock_vld_r <= lock_vld_r;
        lock_id_r  <= lock_id_r;
        rr_ptr_r   <= rr_ptr_r;
      end

      if (conflict_s && (conflict_cnt_r != {PERF_W{1'b1}})) begin
        conflict_cnt_r <= conflict_cnt_r + PERF_W'(1);
      end else begin
        conflict_cnt_r <= conflict_cnt_r;
      end
    end
  end

  assign ready_in     = ready_s;
  assign valid_out    = valid_out_r;
  assign data_out     = data_out_r;
  assign locked       = lock_vld_r;
  assign conflict_cnt = conflict_cnt_r;

  vx_wb_commit_arb_chk #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_chk (
    .clk      (clk),
    .reset_n  (reset_n),
    .lock_vld (lock_vld_r),
    .accept   (gnt_vld_s),
    .sop      (beat_sop_s),
    .valid_in (valid_in),
    .ready_in (ready_s)
  );

endmodule

// File: tb/tb_vx_wb_commit_arb.sv
// ---------------------------------------------------------------------------
// Testbench for vx_wb_commit_arb: table of per-cycle vectors with
// hand-computed ready_in / valid_out / locked / conflict_cnt, expected
// data_out rebuilt from the previous row's granted port, plus a hand-written
// saturation sequence with a 4-bit conflict counter.
// ---------------------------------------------------------------------------
module tb_vx_wb_commit_arb;

  localparam int N  = 4;
  localparam int DW = 128;
  localparam int CW = 2;
  localparam int PW = 4;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    valid_in;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    ready_in;
  logic            valid_out;
  logic [DW-1:0]   data_out;
  logic            locked;
  logic [PW-1:0]   conflict_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          rst_n;
    logic [3:0]    vld;
    logic [3:0]    sop;
    logic [3:0]    eop;
    logic [3:0]    rdy;
    logic          vo;
    logic          lk;
    logic [PW-1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  vx_wb_commit_arb #(
    .NUM_INPUTS (N),
    .DATAW      (DW),
    .CU_W       (CW),
    .PERF_W     (PW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .ready_in     (ready_in),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .locked       (locked),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Payload tagged with port and row so every beat is distinguishable.
  function automatic logic [DW-1:0] mk(input int p, input int seq, input logic s, input logic e);
    logic [DW-1:0] d;
    d           = '0;
    d[DW-1 -: 8] = 8'hC5;
    d[23:16]    = 8'(p);
    d[15:8]     = 8'(seq);
    d[CW+1]     = s;
    d[CW]       = e;
    d[CW-1:0]   = 2'(p);
    return d;
  endfunction

  function automatic int oh_idx(input logic [3:0] oh);
    int r;
    r = 0;
    for (int p = 0; p < N; p++) if (oh[p]) r = p;
    return r;
  endfunction

  task automatic add(input logic r, input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                     input logic [3:0] rd, input logic vo, input logic lk, input int c);
    vec_t t;
    t.rst_n = r; t.vld = v; t.sop = s; t.eop = e;
    t.rdy = rd; t.vo = vo; t.lk = lk; t.cnt = PW'(c);
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int row, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0h want=%0h", name, row, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] s, input logic [3:0] e, input int seq);
    reset_n  = r;
    valid_in = v;
    for (int p = 0; p < N; p++) data_in[p*DW +: DW] = mk(p, seq, s[p], e[p]);
  endtask

  initial begin
    reset_n  = 1'b0;
    valid_in = '0;
    data_in  = '0;

    //   rst vld   sop   eop   rdy   vo lk cnt
    // reset held with all ports valid
    add(0, 4'hF, 4'hF, 4'hF, 4'h0, 0, 0, 0);   // 0
    add(0, 4'hF, 4'hF, 4'hF, 4'h0, 0, 0, 0);   // 1
    add(0, 4'hF, 4'hF, 4'hF, 4'h0, 0, 0, 0);   // 2
    // round-robin, single-beat packets
    add(1, 4'hF, 4'hF, 4'hF, 4'h1, 0, 0, 0);   // 3
    add(1, 4'hF, 4'hF, 4'hF, 4'h2, 1, 0, 1);   // 4
    add(1, 4'hF, 4'hF, 4'hF, 4'h4, 1, 0, 2);   // 5
    add(1, 4'hF, 4'hF, 4'hF, 4'h8, 1, 0, 3);   // 6
    add(1, 4'hF, 4'hF, 4'hF, 4'h1, 1, 0, 4);   // 7
    add(1, 4'hF, 4'hF, 4'hF, 4'h2, 1, 0, 5);   // 8
    add(1, 4'hF, 4'hF, 4'hF, 4'h4, 1, 0, 6);   // 9
    add(1, 4'hF, 4'hF, 4'hF, 4'h8, 1, 0, 7);   // 10
    add(1, 4'h0, 4'hF, 4'hF, 4'h0, 1, 0, 8);   // 11
    add(1, 4'h0, 4'hF, 4'hF, 4'h0, 0, 0, 8);   // 12
    // move pointer to 2, then port 2 sends sop/mid/eop against full contention
    add(1, 4'h2, 4'hF, 4'hF, 4'h2, 0, 0, 8);   // 13
    add(1, 4'hF, 4'hF, 4'hB, 4'h4, 1, 0, 8);   // 14 sop
    add(1, 4'hF, 4'hB, 4'hB, 4'h4, 1, 1, 9);   // 15 mid
    add(1, 4'hF, 4'hB, 4'hF, 4'h4, 1, 1, 10);  // 16 eop
    add(1, 4'hF, 4'hF, 4'hF, 4'h8, 1, 0, 11);  // 17 next grant is port 3
    // lock bubble: port 1 packet with a 2-cycle gap, port 0 always valid
    add(1, 4'h1, 4'hF, 4'hF, 4'h1, 1, 0, 12);  // 18
    add(1, 4'h3, 4'hF, 4'hD, 4'h2, 1, 0, 12);  // 19 p1 sop
    add(1, 4'h1, 4'hF, 4'hF, 4'h0, 1, 1, 13);  // 20 bubble
    add(1, 4'h1, 4'hF, 4'hF, 4'h0, 0, 1, 14);  // 21 bubble
    add(1, 4'h3, 4'hD, 4'hF, 4'h2, 0, 1, 15);  // 22 p1 eop, counter at max
    add(1, 4'h1, 4'hF, 4'hF, 4'h1, 1, 0, 15);  // 23 port 0 finally
    add(1, 4'hF, 4'hF, 4'hF, 4'h2, 1, 0, 15);  // 24 saturated
    // reset in the middle of a port-3 packet
    add(1, 4'h8, 4'hF, 4'h7, 4'h8, 1, 0, 15);  // 25 p3 sop
    add(0, 4'hF, 4'h7, 4'h7, 4'h0, 1, 1, 15);  // 26 reset
    add(1, 4'h8, 4'h7, 4'h7, 4'h8, 0, 0, 0);   // 27 mid beat granted, no lock
    add(1, 4'hA, 4'h7, 4'hF, 4'h2, 1, 0, 0);   // 28 lowest valid port wins
    add(1, 4'h8, 4'h7, 4'hF, 4'h8, 1, 0, 1);   // 29
    add(1, 4'h0, 4'hF, 4'hF, 4'h0, 1, 0, 1);   // 30

    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      int   g;
      v = vecs[i];
      @(negedge clk);
      drive(v.rst_n, v.vld, v.sop, v.eop, i);
      #1;
      check("ready_in", i, DW'(ready_in), DW'(v.rdy));
      check("valid_out", i, DW'(valid_out), DW'(v.vo));
      check("locked", i, DW'(locked), DW'(v.lk));
      check("conflict_cnt", i, DW'(conflict_cnt), DW'(v.cnt));
      if (i == 0 || vecs[i-1].rst_n == 1'b0) begin
        check("data_out_reset", i, data_out, '0);
      end else if (v.vo) begin
        g = oh_idx(vecs[i-1].rdy);
        check("data_out", i, data_out, mk(g, i - 1, vecs[i-1].sop[g], vecs[i-1].eop[g]));
      end
    end

    // Saturation: 20 conflict cycles on a 4-bit counter, grants rotate.
    @(negedge clk);
    drive(1'b0, 4'hF, 4'hF, 4'hF, 200);
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      logic [3:0] exp_rdy;
      drive(1'b1, 4'hF, 4'hF, 4'hF, 100 + k);
      #1;
      exp_rdy = 4'h1 << (k % 4);
      check("sat_cnt", 100 + k, DW'(conflict_cnt), DW'((k < 15) ? k : 15));
      check("sat_ready", 100 + k, DW'(ready_in), DW'(exp_rdy));
      @(negedge clk);
    end
    valid_in = '0;
    #1;
    check("sat_final", 120, DW'(conflict_cnt), DW'(15));
    check("sat_last_data", 120, data_out, mk(3, 119, 1'b1, 1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
